// File: rtl/ppbuffer_ctrl_if.sv
// Bundle of the producer, memory and downstream signals around the ping-pong
// buffer sequencer. The master side is the sequencer; the slave side is the
// environment: producer, ping-pong memory and downstream consumer.
//
// Handshake rule for both streams (in_* and out_*): a bit moves on a rising
// edge where valid and ready are both high. The sender keeps valid and data
// stable until that edge, and valid never waits on ready.
interface ppbuffer_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              in_valid;
    logic              in_data;
    logic              in_ready;
    logic              mem_wren;
    logic              mem_wrbank;
    logic [ADDR_W-1:0] mem_wraddress;
    logic              mem_wrdata;
    logic              mem_rden;
    logic              mem_rdbank;
    logic [ADDR_W-1:0] mem_rdaddress;
    logic              mem_q;
    logic              out_valid;
    logic              out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        input  in_valid, in_data, mem_q, out_ready,
        output in_ready, mem_wren, mem_wrbank, mem_wraddress, mem_wrdata,
               mem_rden, mem_rdbank, mem_rdaddress, out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, mem_q, out_ready,
        input  in_ready, mem_wren, mem_wrbank, mem_wraddress, mem_wrdata,
               mem_rden, mem_rdbank, mem_rdaddress, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ppbuffer_ctrl.sv
// Sequencer for a bit-serial ping-pong buffer. It writes incoming bits into
// one bank while the other bank is streamed out in address order. One full
// flag per bank tells whether that bank holds a complete, unread block.
module ppbuffer_ctrl #(
    parameter int BLOCK_SIZE = 192,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  resetN,
    ppbuffer_ctrl_if.master       bus,
    output logic [0:0]            o_dbg_rd_state
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_SIZE - 1);

    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [1:0]        r_full;
    logic [0:0]        r_state;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_wren;
    logic              w_rden;
    logic              w_wr_wrap;
    logic              w_rd_wrap;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;

    // The writer may fill its bank only while that bank is not waiting to be read.
    assign w_in_ready = ~r_full[r_wr_bank];
    assign w_wren     = bus.in_valid & w_in_ready;
    assign w_wr_wrap  = w_wren & (r_wr_addr == LAST_ADDR);

    // Reading is driven straight from the full flag so the first read issues in
    // the same cycle the flag rises; the FSM state is the registered view of it.
    assign w_rden     = r_full[r_rd_bank] & (~r_out_valid | bus.out_ready);
    assign w_rd_wrap  = w_rden & (r_rd_addr == LAST_ADDR);

    // A set and a clear in one cycle always target different banks.
    assign w_set = w_wr_wrap ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr = w_rd_wrap ? (2'b01 << r_rd_bank) : 2'b00;

    assign bus.in_ready      = w_in_ready;
    assign bus.mem_wren      = w_wren;
    assign bus.mem_wrbank    = r_wr_bank;
    assign bus.mem_wraddress = r_wr_addr;
    assign bus.mem_wrdata    = bus.in_data;
    assign bus.mem_rden      = w_rden;
    assign bus.mem_rdbank    = r_rd_bank;
    assign bus.mem_rdaddress = r_rd_addr;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = bus.mem_q;
    assign bus.out_last      = r_out_last;
    assign o_dbg_rd_state    = r_state;

    // Write address and bank advance on every accepted bit, toggling bank at block end.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
        end else if (w_wren) begin
            if (w_wr_wrap) begin
                r_wr_addr <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // Full flags: the writer marks a finished bank, the reader releases a drained one.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
        end
    end

    // Read address and bank advance on every memory read, toggling bank at block end.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
        end else if (w_rden) begin
            if (w_rd_wrap) begin
                r_rd_addr <= '0;
                r_rd_bank <= ~r_rd_bank;
            end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    // Reader FSM: READ while a complete block is being drained, IDLE otherwise.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) r_state <= S_READ;
                end
                S_READ: begin
                    if (w_rd_wrap) begin
                        r_state <= (r_full[~r_rd_bank] | w_set[~r_rd_bank]) ? S_READ : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output stage: valid follows each memory read by one cycle; a stall keeps
    // rden low so the memory output register (and out_data) holds its bit.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_rden) begin
            r_out_valid <= 1'b1;
            r_out_last  <= (r_rd_addr == LAST_ADDR);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ppbuffer_ctrl.sv
// Bench for ppbuffer_ctrl: a 192-bit instance exercised by scenario tasks and
// a 2-bit instance for block-boundary wrapping. The reference model tracks
// only bit counts: complete blocks written versus complete blocks read.
`timescale 1ns/1ps
module tb_ppbuffer_ctrl;
    localparam int BS  = 192;
    localparam int AW  = 9;
    localparam int BS2 = 2;
    localparam int AW2 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    ppbuffer_ctrl_if #(.ADDR_W(AW))  bus ();
    ppbuffer_ctrl_if #(.ADDR_W(AW2)) bus2 ();
    logic [0:0] dbg;
    logic [0:0] dbg2;

    ppbuffer_ctrl #(.BLOCK_SIZE(BS), .ADDR_W(AW)) dut (
        .clk(clk), .resetN(resetN), .bus(bus), .o_dbg_rd_state(dbg)
    );
    ppbuffer_ctrl #(.BLOCK_SIZE(BS2), .ADDR_W(AW2)) dut2 (
        .clk(clk), .resetN(resetN), .bus(bus2), .o_dbg_rd_state(dbg2)
    );

    // Ping-pong memories with a registered output that loads only on rden.
    logic mem_a [0:1][0:BS-1];
    logic q_a;
    always @(posedge clk) begin
        if (bus.mem_wren) mem_a[bus.mem_wrbank][bus.mem_wraddress] <= bus.mem_wrdata;
        if (bus.mem_rden) q_a <= mem_a[bus.mem_rdbank][bus.mem_rdaddress];
    end
    assign bus.mem_q = q_a;

    logic mem_b [0:1][0:BS2-1];
    logic q_b;
    always @(posedge clk) begin
        if (bus2.mem_wren) mem_b[bus2.mem_wrbank][bus2.mem_wraddress] <= bus2.mem_wrdata;
        if (bus2.mem_rden) q_b <= mem_b[bus2.mem_rdbank][bus2.mem_rdaddress];
    end
    assign bus2.mem_q = q_b;

    // ---------------- scoreboard state ----------------
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 0;
    int   acc_cnt, rd_cnt, out_cnt;
    bit   ov_m;
    bit   acc_flag;
    logic [0:0] exp_q[$];
    logic src_q[$];
    logic in_log[$];
    logic out_log[$];
    int   first_in_cyc[$];
    int   first_out_cyc[$];
    bit   held_valid;
    logic held_d;
    int   in_stall_cnt;
    int   rden_last_cyc, rise_cyc;
    bit   watch_rise;

    // Per-cycle scoreboard for the 192-bit instance. Bank/address expectations
    // come from bit counts; readiness from how many whole blocks are unread.
    always @(negedge clk) begin
        if (mon_en && resetN) begin
            int   bi, br;
            bit   e_rdy, e_rden;
            logic [0:0] e_d;
            bi = acc_cnt / BS;
            br = rd_cnt / BS;
            e_rdy  = (bi - br) < 2;
            e_rden = (bi > br) && (!ov_m || bus.out_ready);

            total++;
            if (bus.in_ready !== e_rdy) begin
                bad++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, e_rdy);
            end
            total++;
            if (bus.mem_wren !== (bus.in_valid & e_rdy)) begin
                bad++; $display("FAIL mem_wren cyc=%0d got=%b exp=%b", cyc, bus.mem_wren, bus.in_valid & e_rdy);
            end
            total++;
            if (bus.mem_wraddress !== AW'(acc_cnt % BS)) begin
                bad++; $display("FAIL wraddress cyc=%0d got=%0d exp=%0d", cyc, bus.mem_wraddress, acc_cnt % BS);
            end
            total++;
            if (bus.mem_wrbank !== 1'((acc_cnt / BS) % 2)) begin
                bad++; $display("FAIL wrbank cyc=%0d got=%b exp=%0d", cyc, bus.mem_wrbank, (acc_cnt / BS) % 2);
            end
            if (bus.in_valid && e_rdy) begin
                total++;
                if (bus.mem_wrdata !== bus.in_data) begin
                    bad++; $display("FAIL wrdata cyc=%0d got=%b exp=%b", cyc, bus.mem_wrdata, bus.in_data);
                end
            end
            total++;
            if (bus.mem_rden !== e_rden) begin
                bad++; $display("FAIL rden cyc=%0d got=%b exp=%b", cyc, bus.mem_rden, e_rden);
            end
            total++;
            if (bus.mem_rdaddress !== AW'(rd_cnt % BS)) begin
                bad++; $display("FAIL rdaddress cyc=%0d got=%0d exp=%0d", cyc, bus.mem_rdaddress, rd_cnt % BS);
            end
            total++;
            if (bus.mem_rdbank !== 1'((rd_cnt / BS) % 2)) begin
                bad++; $display("FAIL rdbank cyc=%0d got=%b exp=%0d", cyc, bus.mem_rdbank, (rd_cnt / BS) % 2);
            end
            total++;
            if (bus.out_valid !== ov_m) begin
                bad++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, ov_m);
            end

            // Stalled output must hold its bit.
            if (ov_m && !bus.out_ready) begin
                if (held_valid) begin
                    total++;
                    if (bus.out_data !== held_d) begin
                        bad++; $display("FAIL stall_stable cyc=%0d got=%b exp=%b", cyc, bus.out_data, held_d);
                    end
                end else begin
                    held_valid = 1;
                    held_d = bus.out_data;
                end
            end else begin
                held_valid = 0;
            end

            // Output handshake against the expected queue.
            if (ov_m && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL out_extra cyc=%0d got=%b exp=none", cyc, bus.out_data);
                end else begin
                    e_d = exp_q.pop_front();
                    if (bus.out_data !== e_d) begin
                        bad++; $display("FAIL out_data cyc=%0d bit=%0d got=%b exp=%b", cyc, out_cnt, bus.out_data, e_d);
                    end
                end
                total++;
                if (bus.out_last !== 1'((out_cnt % BS) == BS - 1)) begin
                    bad++; $display("FAIL out_last cyc=%0d bit=%0d got=%b exp=%b", cyc, out_cnt, bus.out_last, (out_cnt % BS) == BS - 1);
                end
                if (out_cnt % BS == 0) first_out_cyc.push_back(cyc);
                out_log.push_back(bus.out_data);
                out_cnt++;
            end

            acc_flag = bus.in_valid && e_rdy;
            if (acc_flag) begin
                exp_q.push_back(bus.in_data);
                in_log.push_back(bus.in_data);
                if (acc_cnt % BS == 0) first_in_cyc.push_back(cyc);
                acc_cnt++;
            end
            if (!bus.in_ready) in_stall_cnt++;
            if (e_rden && rd_cnt == BS - 1) rden_last_cyc = cyc;
            if (watch_rise && bus.in_ready && rise_cyc < 0) rise_cyc = cyc;
            if (e_rden) rd_cnt++;
            ov_m = e_rden ? 1'b1 : (bus.out_ready ? 1'b0 : ov_m);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        mon_en = 0;
        resetN = 1'b0;
        bus.in_valid = 1'b0;  bus.in_data = 1'b0;  bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = 1'b0; bus2.out_ready = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        acc_cnt = 0; rd_cnt = 0; out_cnt = 0; ov_m = 0; acc_flag = 0;
        exp_q.delete(); src_q.delete(); in_log.delete(); out_log.delete();
        first_in_cyc.delete(); first_out_cyc.delete();
        held_valid = 0; in_stall_cnt = 0;
        rden_last_cyc = -1; rise_cyc = -1; watch_rise = 0;
        mon_en = 1;
    endtask

    // rmode: 0 = out_ready low, 1 = high, 2 = random 50%.
    task automatic drive_cycle(input int rmode);
        bus.out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
        bus.in_valid  = (src_q.size() > 0);
        bus.in_data   = (src_q.size() > 0) ? src_q[0] : 1'b0;
        acc_flag = 0;
        @(posedge clk); #1;
        if (acc_flag) void'(src_q.pop_front());
    endtask

    task automatic run_cycles(input int rmode, input int n);
        for (int i = 0; i < n; i++) drive_cycle(rmode);
    endtask

    task automatic run_drain(input int rmode, input int maxc, output bit done);
        done = 0;
        for (int i = 0; i < maxc; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !ov_m) break;
            drive_cycle(rmode);
        end
        done = (src_q.size() == 0 && exp_q.size() == 0 && !ov_m);
    endtask

    task automatic push_random_blocks(input int n);
        for (int i = 0; i < n * BS; i++) src_q.push_back(1'($urandom_range(0, 1)));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.mem_wraddress !== '0) begin bad++; $display("FAIL reset_wraddress got=%0d exp=0", bus.mem_wraddress); end
        total++; if (bus.mem_rdaddress !== '0) begin bad++; $display("FAIL reset_rdaddress got=%0d exp=0", bus.mem_rdaddress); end
        total++; if (bus.mem_rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b exp=0", bus.mem_rden); end
        total++; if (dbg !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", dbg); end
        total++; if (bus2.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready2 got=%b exp=1", bus2.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_block();
        logic [BS-1:0] pat;
        logic [BS-1:0] got;
        bit done;
        do_reset();
        pat = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
        for (int i = 0; i < BS; i++) src_q.push_back(pat[i]);
        run_drain(1, 600, done);
        total++; if (!done) begin bad++; $display("FAIL single_timeout got=%0d_bits exp=%0d", out_log.size(), BS); end
        got = '0;
        for (int i = 0; i < BS && i < out_log.size(); i++) got[i] = out_log[i];
        total++;
        if (out_log.size() != BS || got !== pat) begin
            bad++; $display("FAIL single_block got=%h exp=%h", got, pat);
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        int mism;
        do_reset();
        push_random_blocks(4);
        run_drain(1, 1200, done);
        total++; if (!done) begin bad++; $display("FAIL b2b_timeout got=%0d_bits exp=%0d", out_log.size(), 4 * BS); end
        total++; if (in_stall_cnt != 0) begin bad++; $display("FAIL b2b_in_ready got=%0d_low_cycles exp=0", in_stall_cnt); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= first_out_cyc.size() || k >= first_in_cyc.size()) begin
                bad++; $display("FAIL b2b_latency block=%0d got=missing exp=193", k);
            end else if (first_out_cyc[k] - first_in_cyc[k] != 193) begin
                bad++; $display("FAIL b2b_latency block=%0d got=%0d exp=193", k, first_out_cyc[k] - first_in_cyc[k]);
            end
        end
        mism = 0;
        for (int i = 0; i < in_log.size() && i < out_log.size(); i++) if (out_log[i] !== in_log[i]) mism++;
        total++;
        if (mism != 0 || out_log.size() != 4 * BS) begin
            bad++; $display("FAIL b2b_data got=%0d_bits_%0d_wrong exp=%0d_bits_0_wrong", out_log.size(), mism, 4 * BS);
        end
    endtask

    task automatic test_backpressure();
        bit done;
        do_reset();
        push_random_blocks(3);
        run_cycles(0, 420);
        total++; if (acc_cnt != 2 * BS) begin bad++; $display("FAIL bp_accepts got=%0d exp=%0d", acc_cnt, 2 * BS); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        watch_rise = 1;
        run_drain(1, 1500, done);
        total++; if (!done) begin bad++; $display("FAIL bp_timeout got=%0d_bits exp=%0d", out_log.size(), 3 * BS); end
        total++;
        if (rden_last_cyc < 0 || rise_cyc != rden_last_cyc + 1) begin
            bad++; $display("FAIL bp_ready_rise got=%0d exp=%0d", rise_cyc, rden_last_cyc + 1);
        end
    endtask

    task automatic test_random_ready();
        bit done;
        int mism;
        do_reset();
        push_random_blocks(3);
        run_drain(2, 3000, done);
        total++; if (!done) begin bad++; $display("FAIL rnd_timeout got=%0d_bits exp=%0d", out_log.size(), 3 * BS); end
        mism = 0;
        for (int i = 0; i < in_log.size() && i < out_log.size(); i++) if (out_log[i] !== in_log[i]) mism++;
        total++;
        if (mism != 0 || out_log.size() != 3 * BS) begin
            bad++; $display("FAIL rnd_data got=%0d_bits_%0d_wrong exp=%0d_bits_0_wrong", out_log.size(), mism, 3 * BS);
        end
    endtask

    task automatic test_mid_reset();
        bit done;
        int mism;
        logic blk[$];
        do_reset();
        push_random_blocks(2);
        run_cycles(1, BS + 100);
        do_reset();
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
        total++;
        if (bus.mem_wraddress !== '0 || bus.mem_rdaddress !== '0) begin
            bad++; $display("FAIL mid_addr got=%0d/%0d exp=0/0", bus.mem_wraddress, bus.mem_rdaddress);
        end
        @(posedge clk); #1;
        for (int i = 0; i < BS; i++) blk.push_back(1'($urandom_range(0, 1)));
        src_q = blk;
        run_drain(1, 600, done);
        total++; if (!done) begin bad++; $display("FAIL mid_timeout got=%0d_bits exp=%0d", out_log.size(), BS); end
        mism = 0;
        for (int i = 0; i < BS && i < out_log.size(); i++) if (out_log[i] !== blk[i]) mism++;
        total++;
        if (mism != 0 || out_log.size() != BS) begin
            bad++; $display("FAIL mid_data got=%0d_bits_%0d_wrong exp=%0d_bits_0_wrong", out_log.size(), mism, BS);
        end
    endtask

    // Two-bit blocks: every other accepted bit wraps the write side, so bank
    // toggling, both-banks-full blocking and out_last are exercised densely.
    task automatic test_small_block();
        int a2, r2, o2, bi, br;
        bit ov2, e_rdy, e_rden;
        logic [0:0] q2[$];
        logic [0:0] e_d;
        do_reset();
        a2 = 0; r2 = 0; o2 = 0; ov2 = 0;
        for (int c = 0; c < 120; c++) begin
            bus2.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus2.in_data   = 1'($urandom_range(0, 1));
            bus2.out_ready = (c < 20) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            bi = a2 / BS2;
            br = r2 / BS2;
            e_rdy  = (bi - br) < 2;
            e_rden = (bi > br) && (!ov2 || bus2.out_ready);
            total++; if (bus2.in_ready !== e_rdy) begin bad++; $display("FAIL s_in_ready cyc=%0d got=%b exp=%b", cyc, bus2.in_ready, e_rdy); end
            total++; if (bus2.mem_wraddress !== AW2'(a2 % BS2)) begin bad++; $display("FAIL s_wraddress cyc=%0d got=%0d exp=%0d", cyc, bus2.mem_wraddress, a2 % BS2); end
            total++; if (bus2.mem_wrbank !== 1'((a2 / BS2) % 2)) begin bad++; $display("FAIL s_wrbank cyc=%0d got=%b exp=%0d", cyc, bus2.mem_wrbank, (a2 / BS2) % 2); end
            total++; if (bus2.mem_rden !== e_rden) begin bad++; $display("FAIL s_rden cyc=%0d got=%b exp=%b", cyc, bus2.mem_rden, e_rden); end
            total++; if (bus2.mem_rdaddress !== AW2'(r2 % BS2)) begin bad++; $display("FAIL s_rdaddress cyc=%0d got=%0d exp=%0d", cyc, bus2.mem_rdaddress, r2 % BS2); end
            total++; if (bus2.mem_rdbank !== 1'((r2 / BS2) % 2)) begin bad++; $display("FAIL s_rdbank cyc=%0d got=%b exp=%0d", cyc, bus2.mem_rdbank, (r2 / BS2) % 2); end
            total++; if (bus2.out_valid !== ov2) begin bad++; $display("FAIL s_out_valid cyc=%0d got=%b exp=%b", cyc, bus2.out_valid, ov2); end
            if (ov2 && bus2.out_ready) begin
                total++;
                if (q2.size() == 0) begin
                    bad++; $display("FAIL s_out_extra cyc=%0d got=%b exp=none", cyc, bus2.out_data);
                end else begin
                    e_d = q2.pop_front();
                    if (bus2.out_data !== e_d) begin bad++; $display("FAIL s_out_data cyc=%0d got=%b exp=%b", cyc, bus2.out_data, e_d); end
                end
                total++;
                if (bus2.out_last !== 1'((o2 % BS2) == BS2 - 1)) begin
                    bad++; $display("FAIL s_out_last cyc=%0d got=%b exp=%b", cyc, bus2.out_last, (o2 % BS2) == BS2 - 1);
                end
                o2++;
            end
            if (bus2.in_valid && e_rdy) begin
                q2.push_back(bus2.in_data);
                a2++;
            end
            if (e_rden) r2++;
            ov2 = e_rden ? 1'b1 : (bus2.out_ready ? 1'b0 : ov2);
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b0;
        total++; if (o2 < 10) begin bad++; $display("FAIL s_progress got=%0d_outputs exp=at_least_10", o2); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_random_ready();
        test_mid_reset();
        test_small_block();
        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
